// File: rtl/pong_pkg.sv
// Shared types and widths for the Pong game-flow logic.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam int unsigned SCORE_W = 4;

  // Larger of two unsigned values, used to size shared frame counters.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/score_ctrl_if.sv
// Event pulses into and game status out of the Pong scoring controller.
interface score_ctrl_if;
  import pong_pkg::*;

  logic               frame;
  logic               start;
  logic               point_l;
  logic               point_r;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic               play;
  logic               serve;
  logic               serve_dir;
  logic               game_over;
  logic               winner;
  logic               show_score;

  modport master (
    output frame, start, point_l, point_r,
    input  score_l, score_r, play, serve, serve_dir, game_over, winner, show_score
  );

  modport slave (
    input  frame, start, point_l, point_r,
    output score_l, score_r, play, serve, serve_dir, game_over, winner, show_score
  );

endinterface

// File: rtl/frame_timer.sv
// Frame-pulse counter with synchronous clear and a terminal-count flag
// against a runtime limit; wraps to zero on terminal count.
module frame_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic             clear,
  input  logic             en,
  input  logic             frame,
  input  logic [CNT_W-1:0] limit,
  output logic             tc_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] last_c;

  assign last_c = CNT_W'(limit - CNT_W'(1));
  assign tc_c   = en && frame && (cnt_q == last_c);

  // Clear outranks counting so a transition on a frame edge starts from zero.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en && frame) begin
      cnt_q <= tc_c ? '0 : CNT_W'(cnt_q + CNT_W'(1));
    end
  end

endmodule

// File: rtl/score_ctrl.sv
// Pong game-flow controller: sequences serve/play/point/game-over,
// owns both scores and blinks the score display once a game is won.
module score_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic         clk_pix,
  input  logic         rst_pix,
  score_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(max_u(SERVE_FRAMES, BLINK_FRAMES) + 1);
  localparam logic [SCORE_W-1:0] WIN_L   = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   SERVE_L = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]   BLINK_L = CNT_W'(BLINK_FRAMES);

  game_state_t        state_q, state_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic               play_q, play_d;
  logic               serve_q, serve_d;
  logic               serve_dir_q, serve_dir_d;
  logic               game_over_q, game_over_d;
  logic               winner_q, winner_d;
  logic               show_q, show_d;

  logic               tmr_clr_c;
  logic               tmr_en_c;
  logic [CNT_W-1:0]   tmr_limit_c;
  logic               tmr_tc_c;

  // One timer serves both the serve delay and the blink half-period.
  assign tmr_en_c    = (state_q == SERVE) || (state_q == OVER);
  assign tmr_limit_c = (state_q == OVER) ? BLINK_L : SERVE_L;

  frame_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .clear   (tmr_clr_c),
    .en      (tmr_en_c),
    .frame   (bus.frame),
    .limit   (tmr_limit_c),
    .tc_c    (tmr_tc_c)
  );

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state_q     <= IDLE;
      score_l_q   <= '0;
      score_r_q   <= '0;
      play_q      <= 1'b0;
      serve_q     <= 1'b0;
      serve_dir_q <= 1'b1;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
      show_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      play_q      <= play_d;
      serve_q     <= serve_d;
      serve_dir_q <= serve_dir_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      show_q      <= show_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    play_d      = play_q;
    serve_d     = 1'b0;
    serve_dir_d = serve_dir_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    show_d      = show_q;
    tmr_clr_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = SERVE;
          tmr_clr_c = 1'b1;
        end
      end

      SERVE: begin
        if (tmr_tc_c) begin
          state_d = PLAY;
          serve_d = 1'b1;
          play_d  = 1'b1;
        end
      end

      PLAY: begin
        if (bus.point_l && bus.point_r) begin
          // Simultaneous exits count as a draw: re-serve with no score change.
          state_d   = SERVE;
          play_d    = 1'b0;
          tmr_clr_c = 1'b1;
        end else if (bus.point_l) begin
          if (score_l_q < WIN_L) score_l_d = SCORE_W'(score_l_q + SCORE_W'(1));
          serve_dir_d = 1'b1;
          play_d      = 1'b0;
          tmr_clr_c   = 1'b1;
          if (score_l_d == WIN_L) begin
            state_d     = OVER;
            winner_d    = 1'b0;
            game_over_d = 1'b1;
          end else begin
            state_d = SERVE;
          end
        end else if (bus.point_r) begin
          if (score_r_q < WIN_L) score_r_d = SCORE_W'(score_r_q + SCORE_W'(1));
          serve_dir_d = 1'b0;
          play_d      = 1'b0;
          tmr_clr_c   = 1'b1;
          if (score_r_d == WIN_L) begin
            state_d     = OVER;
            winner_d    = 1'b1;
            game_over_d = 1'b1;
          end else begin
            state_d = SERVE;
          end
        end
      end

      OVER: begin
        if (bus.start) begin
          // Loser of the finished game gets the first serve.
          state_d     = SERVE;
          score_l_d   = '0;
          score_r_d   = '0;
          game_over_d = 1'b0;
          show_d      = 1'b1;
          serve_dir_d = ~winner_q;
          tmr_clr_c   = 1'b1;
        end else if (tmr_tc_c) begin
          show_d = ~show_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.score_l    = score_l_q;
  assign bus.score_r    = score_r_q;
  assign bus.play       = play_q;
  assign bus.serve      = serve_q;
  assign bus.serve_dir  = serve_dir_q;
  assign bus.game_over  = game_over_q;
  assign bus.winner     = winner_q;
  assign bus.show_score = show_q;

endmodule

// File: tb/tb_score_ctrl.sv
// Directed bench for score_ctrl with WIN_SCORE=3, SERVE_FRAMES=2, BLINK_FRAMES=2.
module tb_score_ctrl;
  import pong_pkg::*;

  logic clk_pix = 1'b0;
  logic rst_pix = 1'b1;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  score_ctrl_if sif ();

  score_ctrl #(
    .WIN_SCORE    (3),
    .SERVE_FRAMES (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .bus     (sif.slave)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic pulse(input bit f, input bit s, input bit pl, input bit pr);
    sif.frame   = f;
    sif.start   = s;
    sif.point_l = pl;
    sif.point_r = pr;
    tick();
    sif.frame   = 1'b0;
    sif.start   = 1'b0;
    sif.point_l = 1'b0;
    sif.point_r = 1'b0;
  endtask

  task automatic check_scores(input string tag, input int l, input int r);
    check({tag, "_score_l"}, int'(sif.score_l), l);
    check({tag, "_score_r"}, int'(sif.score_r), r);
  endtask

  task automatic check_state(input string tag, input game_state_t exp);
    check({tag, "_state"}, int'(dut.state_q), int'(exp));
  endtask

  // Two frame pulses from a freshly cleared SERVE: launch on the second.
  task automatic serve_cycle(input string tag, input int dir);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check({tag, "_no_early_serve"}, int'(sif.serve), 0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check({tag, "_serve"}, int'(sif.serve), 1);
    check({tag, "_play"}, int'(sif.play), 1);
    check({tag, "_dir"}, int'(sif.serve_dir), dir);
    tick();
    check({tag, "_serve_1cyc"}, int'(sif.serve), 0);
    check_state(tag, PLAY);
  endtask

  initial begin
    int exp_blink[6] = '{1, 0, 0, 1, 1, 0};
    sif.frame   = 1'b0;
    sif.start   = 1'b0;
    sif.point_l = 1'b0;
    sif.point_r = 1'b0;
    tick();
    tick();
    rst_pix = 1'b0;

    check_scores("rst", 0, 0);
    check("rst_play", int'(sif.play), 0);
    check("rst_serve", int'(sif.serve), 0);
    check("rst_dir", int'(sif.serve_dir), 1);
    check("rst_over", int'(sif.game_over), 0);
    check("rst_winner", int'(sif.winner), 0);
    check("rst_show", int'(sif.show_score), 1);
    check_state("rst", IDLE);

    // Points and frames are ignored while idle.
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    check_scores("idle_pt", 0, 0);
    check_state("idle_pt", IDLE);

    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check_state("start", SERVE);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check_scores("serve_pt", 0, 0);
    check_state("serve_pt", SERVE);
    serve_cycle("srv1", 1);
    check_scores("srv1", 0, 0);

    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check_state("play_start", PLAY);
    check("play_start_play", int'(sif.play), 1);

    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check_scores("pl1", 1, 0);
    check("pl1_play", int'(sif.play), 0);
    check("pl1_dir", int'(sif.serve_dir), 1);
    check_state("pl1", SERVE);
    serve_cycle("srv2", 1);

    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check_scores("pr1", 1, 1);
    check("pr1_dir", int'(sif.serve_dir), 0);
    serve_cycle("srv3", 0);

    // Draw: frame coincides too; counter must restart.
    pulse(1'b1, 1'b0, 1'b1, 1'b1);
    check_scores("draw", 1, 1);
    check("draw_dir", int'(sif.serve_dir), 0);
    check("draw_play", int'(sif.play), 0);
    check_state("draw", SERVE);
    serve_cycle("srv4", 0);

    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check_scores("pr2", 1, 2);
    serve_cycle("srv5", 0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check_scores("win", 1, 3);
    check("win_over", int'(sif.game_over), 1);
    check("win_winner", int'(sif.winner), 1);
    check("win_play", int'(sif.play), 0);
    check("win_show", int'(sif.show_score), 1);
    check_state("win", OVER);

    for (int i = 0; i < 6; i++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("blink%0d", i), int'(sif.show_score), exp_blink[i]);
    end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check_scores("over_pt", 1, 3);
    check_state("over_pt", OVER);

    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check_scores("restart", 0, 0);
    check("restart_over", int'(sif.game_over), 0);
    check("restart_show", int'(sif.show_score), 1);
    check("restart_dir", int'(sif.serve_dir), 0);
    check_state("restart", SERVE);
    serve_cycle("srv6", 0);

    // Build 2/1 and reset in the middle of the serve delay.
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    serve_cycle("srv7", 1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    serve_cycle("srv8", 1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check_scores("pre_rst", 2, 1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    rst_pix = 1'b1;
    tick();
    rst_pix = 1'b0;
    check_state("mid_rst", IDLE);
    check_scores("mid_rst", 0, 0);
    check("mid_rst_dir", int'(sif.serve_dir), 1);
    check("mid_rst_show", int'(sif.show_score), 1);
    check("mid_rst_play", int'(sif.play), 0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("post_rst_serve", int'(sif.serve), 0);
    check_state("post_rst", IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/score_ctrl.md
Name: score_ctrl

Overview:
- Game-flow controller for Pong scoring.
- Sequences rounds: wait for start, serve delay, play, point award, game over.
- Owns both score registers and drives them into the score display (score_l, score_r, 0-9).
- Gates ball motion (play/serve) and blinks the score digits at game over via show_score, which the top level ANDs with the score pixel.

Parameters:
- WIN_SCORE, 9, score that ends the game; legal range 1-9.
- SERVE_FRAMES, 60, frames held in SERVE before the ball launches; must be ≥1.
- BLINK_FRAMES, 30, frames per show_score half-period in OVER; must be ≥1.

Ports:
- clk_pix  input  1  pixel clock, only clock.
- rst_pix  input  1  synchronous reset, active-high.
- frame  input  1  one-cycle pulse at start of each frame.
- start  input  1  one-cycle start/restart pulse (debounced upstream).
- point_l  input  1  one-cycle pulse: left player scored (ball exited right).
- point_r  input  1  one-cycle pulse: right player scored (ball exited left).
- score_l  output  4  left score, 0..WIN_SCORE.
- score_r  output  4  right score, 0..WIN_SCORE.
- play  output  1  ball motion enable.
- serve  output  1  one-cycle ball launch/recentre pulse.
- serve_dir  output  1  launch direction: 1 = rightward, 0 = leftward.
- game_over  output  1  high in OVER.
- winner  output  1  valid when game_over: 0 = left, 1 = right.
- show_score  output  1  score display enable; blinks in OVER.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; score_l = score_r = 0; play = 0; serve = 0; serve_dir = 1; game_over = 0; winner = 0; show_score = 1; frame counter = 0.
- Reset applies at any time, including mid-PLAY or mid-SERVE, and takes priority over every other input.

States:
- IDLE: start → SERVE, counter cleared. All other inputs ignored.
- SERVE: counter increments on each frame pulse. On the edge where frame=1 and counter = SERVE_FRAMES-1: state ← PLAY, serve ← 1 for exactly one cycle, play ← 1 (same edge). Points and start are ignored.
- PLAY, point_l only: score_l ← score_l+1, serve_dir ← 1 (serve toward the conceding player). If the new value = WIN_SCORE: → OVER, winner ← 0. Otherwise → SERVE. Counter cleared, play ← 0, all on that same edge (1-cycle latency).
- PLAY, point_r only: mirror of point_l; serve_dir ← 0, winner ← 1.
- PLAY, point_l and point_r in the same cycle: draw. No score change, serve_dir unchanged, → SERVE.
- PLAY: start is ignored.
- OVER: game_over = 1, play = 0. Counter counts frames; when frame=1 and counter = BLINK_FRAMES-1, show_score toggles and counter ← 0.
- OVER, start: scores ← 0, game_over ← 0, show_score ← 1, counter ← 0, → SERVE. serve_dir ← ~winner, so the loser of the last game receives the first serve.

General rules:
- show_score = 1 in every state except OVER.
- Scores saturate at WIN_SCORE; no increment occurs outside PLAY, so values never exceed 9.
- Counter width: $clog2(max(SERVE_FRAMES, BLINK_FRAMES)+1). The counter is never compared to 0 before it is cleared.
- frame coinciding with a point or start: the state transition wins and the counter clears.

Decomposition:
- Package pong_pkg holds:
  - typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} game_state_t;
  - localparam SCORE_W = 4.
- One sub-module, frame_timer: clear, frame-pulse count, and a terminal-count compare against a runtime limit. It is reused for the serve delay and the blink period.
- FSM and score registers stay in score_ctrl.

Test Plan (WIN_SCORE=3, SERVE_FRAMES=2, BLINK_FRAMES=2):
- Reset, then start, then 2 frame pulses → serve high exactly one cycle after the 2nd frame edge, play=1, serve_dir=1, scores 0/0.
- In PLAY, point_l pulse → next cycle score_l=1, play=0, serve_dir=1, state SERVE. After 2 frames, serve pulses again.
- Drive point_r three times, each separated by a full serve cycle → score_r=3, game_over=1, winner=1, play=0. show_score toggles every 2 frames (1,1,0,0,1,...).
- point_l and point_r in the same PLAY cycle → scores unchanged, serve_dir unchanged, state SERVE.
- Point pulses during IDLE/SERVE and start during PLAY → no score or state change.
- Reset asserted mid-SERVE with score 2/1 → next cycle IDLE, scores 0/0, serve_dir=1, show_score=1.
- Start in OVER after a right win → scores 0/0, game_over=0, serve_dir=0, serve after 2 frames.
